multiport_arbiter: RTL and testbench

MULTIPORT_ARBITER -- requirements
Module: multiport_arbiter

---
 rtl/multiport_arbiter_pkg.sv | 17 +
 rtl/arb_select.sv | 47 ++++
 rtl/multiport_arbiter.sv | 114 +++++++++++
 tb/tb_multiport_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_arbiter_pkg.sv
// rtl/multiport_arbiter_pkg.sv - shared FSM state, arbitration modes and default widths
package multiport_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_BLOCK_W = 512;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational winner selection, round-robin or fixed priority with aging
module arb_select
  import multiport_arbiter_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int MODE   = ARB_RR,
  parameter int IDX_W  = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  input  logic [NPORTS-1:0] age_sat,
  output logic [NPORTS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  // First pass picks the preferred candidates (at/after rr_ptr, or aged-out ports);
  // the second pass falls back to the lowest requesting index.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (MODE == ARB_RR) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!grant_valid && req[i] && (IDX_W'(i) >= rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!grant_valid && req[i] && age_sat[i]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/multiport_arbiter.sv
// rtl/multiport_arbiter.sv - N-port cache-block arbiter in front of a single memory controller
module multiport_arbiter
  import multiport_arbiter_pkg::*;
#(
  parameter int NPORTS    = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BLOCK_W   = DEF_BLOCK_W,
  parameter int MODE      = ARB_RR,
  parameter int AGE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS-1:0]           port_req,
  input  logic [NPORTS-1:0]           port_wr_en,
  input  logic [NPORTS*ADDR_W-1:0]    port_addr,
  input  logic [NPORTS*BLOCK_W-1:0]   port_data_in,
  output logic [NPORTS*BLOCK_W-1:0]   port_data_out,
  output logic [NPORTS-1:0]           port_complete,
  output logic                        mem_req,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [BLOCK_W-1:0]          mem_data_out,
  input  logic [BLOCK_W-1:0]          mem_data_in,
  input  logic                        mem_data_valid
);

  localparam int IDX_W = $clog2(NPORTS);
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, sel_idx, grant_idx;
  logic [NPORTS-1:0] sel_grant, grant, age_sat;
  logic              grant_valid;
  logic [AGE_W-1:0]  age [NPORTS];

  always_comb begin
    age_sat = '0;
    for (int i = 0; i < NPORTS; i++) age_sat[i] = (age[i] == AGE_W'(AGE_LIMIT));
  end

  arb_select #(
    .NPORTS (NPORTS),
    .MODE   (MODE),
    .IDX_W  (IDX_W)
  ) u_select (
    .req         (port_req),
    .rr_ptr      (rr_ptr),
    .age_sat     (age_sat),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_valid) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_data_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request is captured on the IDLE->GRANT edge so mem_req is already up during GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_address   <= '0;
      mem_data_out  <= '0;
      port_complete <= '0;
      port_data_out <= '0;
      rr_ptr        <= '0;
      sel_idx       <= '0;
      sel_grant     <= '0;
      for (int i = 0; i < NPORTS; i++) age[i] <= '0;
    end else begin
      port_complete <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            sel_idx      <= grant_idx;
            sel_grant    <= grant;
            mem_req      <= 1'b1;
            mem_wr_en    <= port_wr_en[grant_idx];
            mem_address  <= port_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_data_out <= port_data_in[grant_idx*BLOCK_W +: BLOCK_W];
            rr_ptr       <= (grant_idx == IDX_W'(NPORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
            for (int i = 0; i < NPORTS; i++) begin
              if (grant[i] || !port_req[i]) age[i] <= '0;
              else if (!age_sat[i])         age[i] <= age[i] + AGE_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (mem_data_valid) begin
            mem_req       <= 1'b0;
            mem_wr_en     <= 1'b0;
            port_complete <= sel_grant;
            if (!mem_wr_en) port_data_out[sel_idx*BLOCK_W +: BLOCK_W] <= mem_data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiport_arbiter.sv
// tb/tb_multiport_arbiter.sv - scoreboard bench: RR 2-port, RR 4-port and fixed-priority instances
module tb_multiport_arbiter;
  import multiport_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int BW = 64;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          wr;
    logic [BW-1:0] data;
  } gexp_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [BW-1:0] dout;
  } dexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [3:0]      req   [3];
  logic [3:0]      wr    [3];
  logic [4*AW-1:0] addr  [3];
  logic [4*BW-1:0] din   [3];
  logic [4*BW-1:0] dout  [3];
  logic [3:0]      cmpl  [3];
  logic            mreq  [3];
  logic            mwr   [3];
  logic [AW-1:0]   maddr [3];
  logic [BW-1:0]   mdout [3];
  int              lat   [3];
  logic            stray [3];

  gexp_t         gq [3][$];
  dexp_t         dq [3][$];
  logic [BW-1:0] dmodel [3][4];

  function automatic logic [BW-1:0] mem_model(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input int g, input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [BW-1:0] d);
    req[g][p]             = r;
    wr[g][p]              = w;
    addr[g][p*AW +: AW]   = a;
    din[g][p*BW +: BW]    = d;
  endtask

  task automatic exp_grant(input int g, input int c, input logic [AW-1:0] a,
                           input logic w, input logic [BW-1:0] d);
    gexp_t e;
    e.cyc = c; e.addr = a; e.wr = w; e.data = d;
    gq[g].push_back(e);
  endtask

  task automatic exp_done(input int g, input int c, input int p, input logic is_read,
                          input logic [AW-1:0] a);
    dexp_t e;
    if (is_read) dmodel[g][p] = mem_model(a);
    e.cyc = c; e.port = p; e.dout = dmodel[g][p];
    dq[g].push_back(e);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int NP = (g == 1) ? 4 : 2;
    localparam int MD = (g == 2) ? ARB_FIXED : ARB_RR;

    logic          mvalid;
    logic [BW-1:0] mdin;
    int            age;
    logic          mreq_q;
    gexp_t         ge;
    dexp_t         de;

    multiport_arbiter #(
      .NPORTS    (NP),
      .ADDR_W    (AW),
      .BLOCK_W   (BW),
      .MODE      (MD),
      .AGE_LIMIT (2)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .port_req       (req[g][NP-1:0]),
      .port_wr_en     (wr[g][NP-1:0]),
      .port_addr      (addr[g][NP*AW-1:0]),
      .port_data_in   (din[g][NP*BW-1:0]),
      .port_data_out  (dout[g][NP*BW-1:0]),
      .port_complete  (cmpl[g][NP-1:0]),
      .mem_req        (mreq[g]),
      .mem_wr_en      (mwr[g]),
      .mem_address    (maddr[g]),
      .mem_data_out   (mdout[g]),
      .mem_data_in    (mdin),
      .mem_data_valid (mvalid)
    );

    // Memory responder: valid arrives lat cycles after the GRANT cycle.
    initial begin
      mvalid = 1'b0;
      mdin   = '0;
      age    = 0;
      forever begin
        @(negedge clk);
        if (mreq[g]) age++;
        else         age = 0;
        mvalid = (mreq[g] && age == lat[g] + 1) || stray[g];
        mdin   = mem_model(maddr[g]);
      end
    end

    initial begin
      mreq_q = 1'b0;
      forever begin
        @(negedge clk);
        if (mreq[g] && !mreq_q) begin
          if (gq[g].size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant[%0d]: got addr %0h at cycle %0d required none", g, maddr[g], cyc);
          end else begin
            ge = gq[g].pop_front();
            chk($sformatf("grant_cycle[%0d]", g), 64'(cyc), 64'(ge.cyc));
            chk($sformatf("grant_addr[%0d]", g), 64'(maddr[g]), 64'(ge.addr));
            chk($sformatf("grant_wr[%0d]", g), 64'(mwr[g]), 64'(ge.wr));
            chk($sformatf("grant_data[%0d]", g), mdout[g], ge.data);
          end
        end
        if (cmpl[g][NP-1:0] != '0) begin
          if (dq[g].size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_complete[%0d]: got %0h at cycle %0d required none", g, cmpl[g][NP-1:0], cyc);
          end else begin
            de = dq[g].pop_front();
            chk($sformatf("done_cycle[%0d]", g), 64'(cyc), 64'(de.cyc));
            chk($sformatf("done_port[%0d]", g), 64'(cmpl[g][NP-1:0]), 64'(1) << de.port);
            chk($sformatf("done_data[%0d]", g), dout[g][de.port*BW +: BW], de.dout);
          end
        end
        mreq_q = mreq[g];
      end
    end
  end

  int   n_wr;
  logic [1:0] seen_cmpl;
  logic seen_req;

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      req[g] = '0; wr[g] = '0; addr[g] = '0; din[g] = '0;
      lat[g] = 1; stray[g] = 1'b0;
      for (int p = 0; p < 4; p++) dmodel[g][p] = '0;
    end
    at(3);
    rst = 1'b0;

    at(4);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_mem_req[%0d]", g), 64'(mreq[g]), 64'd0);
      chk($sformatf("rst_mem_wr[%0d]", g), 64'(mwr[g]), 64'd0);
      chk($sformatf("rst_mem_addr[%0d]", g), 64'(maddr[g]), 64'd0);
      chk($sformatf("rst_mem_data[%0d]", g), mdout[g], 64'd0);
      chk($sformatf("rst_complete[%0d]", g), 64'(cmpl[g][1:0]), 64'd0);
      chk($sformatf("rst_dout[%0d]", g), dout[g][BW-1:0], 64'd0);
    end

    // Two-port round-robin: port0 then port1
    lat[0] = 1;
    exp_grant(0, 11, 32'h1000, 1'b0, 64'h0101);
    exp_done (0, 13, 0, 1'b1, 32'h1000);
    exp_grant(0, 15, 32'h2000, 1'b0, 64'h0202);
    exp_done (0, 17, 1, 1'b1, 32'h2000);
    at(10);
    drive(0, 0, 1'b1, 1'b0, 32'h1000, 64'h0101);
    drive(0, 1, 1'b1, 1'b0, 32'h2000, 64'h0202);
    at(13); req[0][0] = 1'b0;
    at(17); req[0][1] = 1'b0;

    // Port1 write, k=3: wr_en high 4 cycles, complete at t0+5, read data untouched
    at(19);
    lat[0] = 3;
    exp_grant(0, 21, 32'h5000, 1'b1, {8{8'hA5}});
    exp_done (0, 25, 1, 1'b0, 32'h5000);
    n_wr = 0;
    for (int c = 20; c <= 27; c++) begin
      at(c);
      if (c == 20) drive(0, 1, 1'b1, 1'b1, 32'h5000, {8{8'hA5}});
      if (c == 25) drive(0, 1, 1'b0, 1'b0, 32'h5000, 64'h0);
      if (mwr[0]) n_wr++;
    end
    chk("write_wr_en_cycles", 64'(n_wr), 64'd4);

    // Port0 read, request dropped during WAIT
    lat[0] = 2;
    exp_grant(0, 31, 32'h3000, 1'b0, 64'h0);
    exp_done (0, 34, 0, 1'b1, 32'h3000);
    at(30); drive(0, 0, 1'b1, 1'b0, 32'h3000, 64'h0);
    at(32); req[0][0] = 1'b0;

    // Four-port round-robin, all requesting: 0,1,2,3,0
    lat[1] = 1;
    for (int k = 0; k < 5; k++) begin
      exp_grant(1, 41 + 4*k, 32'h100 * ((k % 4) + 1), 1'b0, 64'((k % 4) + 1));
      exp_done (1, 43 + 4*k, k % 4, 1'b1, 32'h100 * ((k % 4) + 1));
    end
    at(40);
    for (int p = 0; p < 4; p++) drive(1, p, 1'b1, 1'b0, 32'h100 * (p + 1), 64'(p + 1));
    at(58); req[1] = '0;

    // Fixed priority with AGE_LIMIT=2: port1 wins the third arbitration
    lat[2] = 1;
    exp_grant(2, 71, 32'h7000, 1'b0, 64'h70);
    exp_done (2, 73, 0, 1'b1, 32'h7000);
    exp_grant(2, 75, 32'h7000, 1'b0, 64'h70);
    exp_done (2, 77, 0, 1'b1, 32'h7000);
    exp_grant(2, 79, 32'h7100, 1'b0, 64'h71);
    exp_done (2, 81, 1, 1'b1, 32'h7100);
    at(70);
    drive(2, 0, 1'b1, 1'b0, 32'h7000, 64'h70);
    drive(2, 1, 1'b1, 1'b0, 32'h7100, 64'h71);
    at(80); req[2] = '0;

    // Reset during WAIT abandons the transaction; stray valid in IDLE is ignored
    lat[0] = 3;
    exp_grant(0, 91, 32'h4000, 1'b0, 64'h0);
    at(90); drive(0, 0, 1'b1, 1'b0, 32'h4000, 64'h0);
    at(92); rst = 1'b1; req[0][0] = 1'b0;
    at(93); rst = 1'b0;
    chk("wait_rst_mem_req", 64'(mreq[0]), 64'd0);
    chk("wait_rst_state", 64'(gen_dut[0].u_dut.state), 64'(ST_IDLE));
    chk("wait_rst_dout0", dout[0][BW-1:0], 64'd0);
    seen_cmpl = '0;
    seen_req  = 1'b0;
    for (int c = 93; c <= 100; c++) begin
      at(c);
      if (c == 95) stray[0] = 1'b1;
      if (c == 97) stray[0] = 1'b0;
      seen_cmpl = seen_cmpl | cmpl[0][1:0];
      seen_req  = seen_req | mreq[0];
    end
    chk("no_pulse_after_rst", 64'(seen_cmpl), 64'd0);
    chk("no_req_after_stray", 64'(seen_req), 64'd0);

    at(104);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("grants_left[%0d]", g), 64'(gq[g].size()), 64'd0);
      chk($sformatf("dones_left[%0d]", g), 64'(dq[g].size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
